// File: rtl/instruction_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// instruction_fetch_sequencer
//
// Owns the program counter of the MIPS core and drives the word address of a
// synchronous-read Instruction_Memory (one-cycle read latency). Fetched words
// are delivered to decode over a valid/ready handshake through a 2-entry
// in-order fetch buffer. Branch/jump redirects flush the fetch path and load
// a new PC. A PC that is misaligned or beyond the end of memory stops
// fetching and raises a sticky fault.
//
// Ports
//   i_clk             rising-edge clock
//   i_rst             synchronous active-high reset
//   o_imem_addr       word address to Instruction_Memory (pc[ADDR_W+1:2])
//   o_imem_req        high in cycles where o_imem_addr is a real fetch
//   i_imem_data       instruction word for the address issued last cycle
//   o_inst_valid      o_inst_out/o_inst_pc hold a deliverable instruction
//   i_inst_ready      decode accepts the head instruction
//   o_inst_out        instruction word at the buffer head
//   o_inst_pc         byte PC of o_inst_out
//   i_redirect_valid  load i_redirect_pc and flush the fetch path
//   i_redirect_pc     byte target PC of the redirect
//   o_fault           sticky illegal-PC flag
//   o_fault_pc        PC that caused the fault
// ---------------------------------------------------------------------------
module instruction_fetch_sequencer #(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic              o_imem_req,
    input  logic [31:0]       i_imem_data,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [31:0]       o_inst_out,
    output logic [31:0]       o_inst_pc,
    input  logic              i_redirect_valid,
    input  logic [31:0]       i_redirect_pc,
    output logic              o_fault,
    output logic [31:0]       o_fault_pc
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_buf_data [2];
    logic [31:0] r_buf_pc   [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        r_fault;
    logic [31:0] r_fault_pc;

    logic        w_pc_legal;
    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_occupancy;
    logic        w_space;
    logic        w_issue;
    logic        w_wr_idx;

    // A PC is legal when word aligned and inside the 2**ADDR_W word memory;
    // there is no wrap, so the first address past the end is illegal.
    assign w_pc_legal  = (r_pc[1:0] == 2'b00) && ((r_pc >> (ADDR_W + 2)) == 32'd0);

    assign w_pop       = o_inst_valid & i_inst_ready;
    assign w_push      = r_inflight;

    // Slots already claimed (buffered plus the word returning this cycle),
    // less the one leaving now; a new fetch is only issued if the buffer can
    // still absorb it when it returns, so the buffer never overflows.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_space     = (w_occupancy - {2'b00, w_pop}) < 3'd2;

    // Reset and redirect both suppress issue in the current cycle: the
    // redirect target is fetched in the following cycle once r_pc holds it.
    assign w_issue     = !i_rst && !i_redirect_valid && (r_state == ST_RUN)
                         && w_pc_legal && w_space;

    // Tail slot is head + count modulo 2; with a full buffer that is the head
    // slot, which is legal only when the head is popping in the same cycle.
    assign w_wr_idx    = r_head + r_count[0];

    assign o_imem_addr  = r_pc[ADDR_W+1:2];
    assign o_imem_req   = w_issue;
    assign o_inst_valid = (r_count != 2'd0);
    assign o_inst_out   = r_buf_data[r_head];
    assign o_inst_pc    = r_buf_pc[r_head];
    assign o_fault      = r_fault;
    assign o_fault_pc   = r_fault_pc;

    // Fetch state machine, PC, in-flight tracking and fetch buffer.
    // Priority: reset, then redirect (flushes everything including the
    // returning word and the current head), then normal issue/push/pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'd0;
            r_head        <= 1'b0;
            r_count       <= 2'd0;
            r_fault       <= 1'b0;
            r_fault_pc    <= 32'd0;
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= 32'd0;
                r_buf_pc[i]   <= 32'd0;
            end
        end else if (i_redirect_valid) begin
            r_state    <= ST_RUN;
            r_pc       <= i_redirect_pc;
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_fault    <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + 32'd4;
            end

            // An illegal PC stops fetching; older words keep draining.
            if ((r_state == ST_RUN) && !w_pc_legal) begin
                r_state    <= ST_FAULT;
                r_fault    <= 1'b1;
                r_fault_pc <= r_pc;
            end

            if (w_push) begin
                r_buf_data[w_wr_idx] <= i_imem_data;
                r_buf_pc[w_wr_idx]   <= r_inflight_pc;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule
